pipeline_divider: RTL



---
 rtl/pipeline_divider_pkg.sv | 6 +
 rtl/pipeline_divider_div_step.sv | 18 +
 rtl/pipeline_divider.sv | 87 ++++++++
 3 files changed

// File: rtl/pipeline_divider_pkg.sv
// pipeline_divider_pkg: shared width default, FSM state type and divide-by-zero quotient.
package pipeline_divider_pkg;
  localparam int N_DEF = 10;
  localparam logic [63:0] DIV0_QUOTIENT = '1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/pipeline_divider_div_step.sv
// pipeline_divider_div_step: one restoring-division step (shift left, trial subtract, restore).
module pipeline_divider_div_step #(
  parameter int N = 10
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] dvs_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] quo_o
);
  logic [N:0]   sh_rem;
  logic [N+1:0] diff;
  assign sh_rem = {rem_i[N-1:0], quo_i[N-1]};
  // Extra top bit of diff is the borrow: set means the trial subtract went negative.
  assign diff   = {1'b0, sh_rem} - {2'b0, dvs_i};
  assign rem_o  = diff[N+1] ? sh_rem : diff[N:0];
  assign quo_o  = {quo_i[N-2:0], ~diff[N+1]};
endmodule

// File: rtl/pipeline_divider.sv
// pipeline_divider: iterative restoring divider recovering X = F / D and R = F % D.
module pipeline_divider
  import pipeline_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic [N-1:0] X,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);
  localparam int CW = $clog2(N + 1);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d, dvs_q, x_q, r_q;
  logic          busy_q, done_q, dz_q;
  pipeline_divider_div_step #(.N(N)) u_step (
    .rem_i(rem_q),
    .quo_i(quo_q),
    .dvs_i(dvs_q),
    .rem_o(rem_d),
    .quo_o(quo_d)
  );
  // Results are loaded on the edge entering DONE so X/R/done appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      x_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          quo_q <= F;
          dvs_q <= D;
          rem_q <= '0;
          cnt_q <= CW'(N);
          dz_q  <= (D == '0);
          if (D == '0) begin
            x_q     <= N'(DIV0_QUOTIENT);
            r_q     <= F;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            x_q     <= quo_d;
            r_q     <= rem_d[N-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign X        = x_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
endmodule
